// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and receiver: frame states,
// line levels and the default bit period.
package serial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Producer-side handshake and serial line of the frame transmitter.
interface serial_frame_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              tx_line;
   logic              tx_busy;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_line, tx_busy
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_line, tx_busy
   );
endinterface

// File: rtl/baud_tick_gen.sv
// Modulo-CLKS_PER_BIT counter; tick marks the last cycle of each bit period.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);
endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start, DATA_W bits LSB first,
// optional even parity, stop.
//
//   state  | meaning
//   IDLE   | line high, ready for a byte
//   START  | driving the start bit
//   DATA   | driving data bits, LSB first
//   PARITY | driving the captured even-parity bit
//   STOP   | driving the stop bit
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int PARITY_EN    = 1
) (
   input  logic                clk,
   input  logic                reset,
   serial_frame_tx_if.slave    bus
);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

   localparam logic [2:0] IDLE   = ST_IDLE;
   localparam logic [2:0] START  = ST_START;
   localparam logic [2:0] DATA   = ST_DATA;
   localparam logic [2:0] PARITY = ST_PARITY;
   localparam logic [2:0] STOP   = ST_STOP;

   logic [2:0]        state;
   logic [DATA_W-1:0] shift_q;
   logic [BIT_W-1:0]  bit_cnt;
   logic              parity_q;
   logic              line_q;
   logic              baud_clear;
   logic              tick;

   // Holding the counter clear in IDLE aligns every frame's first bit period.
   assign baud_clear = (state == IDLE);

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (baud_clear),
      .tick  (tick)
   );

   // The line is registered, so each bit is loaded from shift_q[0] on the
   // edge that starts its period and the register shifts in the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shift_q  <= '0;
         bit_cnt  <= '0;
         parity_q <= 1'b0;
         line_q   <= LINE_IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.tx_valid) begin
                  state    <= START;
                  shift_q  <= bus.tx_data;
                  parity_q <= ^bus.tx_data;
                  bit_cnt  <= '0;
                  line_q   <= START_BIT;
               end
            end
            START: begin
               if (tick) begin
                  state   <= DATA;
                  line_q  <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_cnt <= BIT_W'(1);
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        state  <= PARITY;
                        line_q <= parity_q;
                     end else begin
                        state  <= STOP;
                        line_q <= STOP_BIT;
                     end
                  end else begin
                     line_q  <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  state  <= STOP;
                  line_q <= STOP_BIT;
               end
            end
            STOP: begin
               if (tick) begin
                  state  <= IDLE;
                  line_q <= LINE_IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               line_q <= LINE_IDLE;
            end
         endcase
      end
   end

   assign bus.tx_ready = (state == IDLE);
   assign bus.tx_busy  = (state != IDLE);
   assign bus.tx_line  = line_q;
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter that drives one serial line from a byte-wide source.
- Each frame is: start bit (0), DATA_W data bits LSB first, optional even-parity bit, stop bit (1).
- Sits between a register or FIFO producer and the board serial pin.
- It is the sending end for the team's serial receiver and is built from reset-able D-type state registers.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 2.
- PARITY_EN, 1, 1 = insert even-parity bit after the data bits; 0 = omit it.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_W  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has data on tx_data.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- tx_line  output  1  serial output, registered; idles high.
- tx_busy  output  1  a frame is in progress.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, tx_line=1, tx_ready=1, tx_busy=0, shift register=0, bit counter=0, baud counter=0.
- Reset mid-frame: tx_line returns to 1 immediately (asynchronously) and the frame is abandoned. After reset deasserts, the block waits in IDLE.
- Handshake: a transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_ready = (state==IDLE).
  - tx_valid while busy is ignored; no data is lost because tx_ready=0.
  - tx_data is captured into the shift register on the transfer. Later changes on tx_data do not affect the frame.
  - Parity is computed at capture as the XOR of all data bits (even parity).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on transfer. tx_line=0 from the next edge.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: tx_line = shift register bit 0. Shift right once per bit period; count DATA_W bits.
  - DATA -> PARITY after DATA_W bits if PARITY_EN=1; otherwise DATA -> STOP.
  - PARITY: tx_line = captured parity for one bit period, then -> STOP.
  - STOP: tx_line=1 for one bit period, then -> IDLE.
- Bit timing: the baud counter counts 0..CLKS_PER_BIT-1. It reloads to 0 on every state or bit change. Each bit is held exactly CLKS_PER_BIT cycles.
- Frame length: (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles, measured from the first cycle tx_line=0 to the last stop-bit cycle.
- Back-to-back frames: tx_valid held high produces exactly one IDLE cycle (line high) between the stop bit and the next start bit. The inter-frame gap is therefore CLKS_PER_BIT+1 high cycles.
- tx_busy = (state != IDLE), so tx_busy = ~tx_ready.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit counter is $clog2(DATA_W+1) bits. Neither counter wraps outside its terminal compare.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1;
  - the default CLKS_PER_BIT. The receiver uses the same package.
- One sub-module, baud_tick_gen: free-running modulo-CLKS_PER_BIT counter with a synchronous clear input. It outputs a one-cycle tick on the last cycle of each bit period.

Test Plan (CLKS_PER_BIT=4, DATA_W=8, PARITY_EN=1 unless noted):
- Reset: assert reset mid-DATA of a frame carrying 0xFF -> tx_line=1 within the same cycle, tx_ready=1, tx_busy=0. After release, line stays 1 with no valid.
- Single frame 0xA5 -> tx_line sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 0(parity), 1. Total 44 cycles, then tx_ready=1.
- Parity, odd count: send 0x07 -> parity bit 1. Send 0x00 -> parity bit 0, frame 0,0×8,0,1.
- Back-to-back: hold tx_valid with 0x3C then 0xC3 -> second transfer 45 cycles after the first. One IDLE cycle plus a 4-cycle stop bit gives a line-high gap of 5 cycles. Both frames are bit-exact.
- Busy ignore: pulse tx_valid with 0x55 at cycle 10 of a 0x12 frame -> 0x55 is not transmitted and only 0x12 appears on the line.
- PARITY_EN=0, CLKS_PER_BIT=2: send 0x81 -> line 0,1,0,0,0,0,0,0,1,1, each bit 2 cycles, 20 cycles total.
